// File: rtl/process_scheduler_pkg.sv
// Shared types and defaults for the process scheduler, quantum counter and PC mux.
package process_scheduler_pkg;

    localparam int NPROC_DEFAULT = 4;
    localparam int PID_W_DEFAULT = $clog2(NPROC_DEFAULT);
    localparam int PC_W_DEFAULT  = 32;

    typedef enum logic [1:0] {
        ENTRY_FREE    = 2'd0,
        ENTRY_READY   = 2'd1,
        ENTRY_RUNNING = 2'd2,
        ENTRY_BLOCKED = 2'd3
    } entry_state_t;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_RUN    = 2'd1,
        FSM_SELECT = 2'd2,
        FSM_LOAD   = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/process_scheduler_if.sv
// Event, create, I/O-completion and PC-load signals between the scheduler and its neighbours.
interface process_scheduler_if
    import process_scheduler_pkg::*;
#(
    parameter int PC_W  = PC_W_DEFAULT,
    parameter int PID_W = PID_W_DEFAULT
);
    logic             quantum_expired;
    logic             io_request;
    logic             proc_end;
    logic [PC_W-1:0]  saved_pc;
    logic             create_valid;
    logic [PC_W-1:0]  create_pc;
    logic             create_ready;
    logic             io_done_valid;
    logic [PID_W-1:0] io_done_pid;
    logic             pc_load;
    logic [PC_W-1:0]  pc_next;
    logic [PID_W-1:0] cur_pid;
    logic             cur_valid;
    logic             sched_busy;

    modport master (
        output quantum_expired, io_request, proc_end, saved_pc,
        output create_valid, create_pc, io_done_valid, io_done_pid,
        input  create_ready, pc_load, pc_next, cur_pid, cur_valid, sched_busy
    );

    modport slave (
        input  quantum_expired, io_request, proc_end, saved_pc,
        input  create_valid, create_pc, io_done_valid, io_done_pid,
        output create_ready, pc_load, pc_next, cur_pid, cur_valid, sched_busy
    );
endinterface

// File: rtl/process_scheduler_rr_picker.sv
// Combinational round-robin search: first set bit of mask at or after start, wrapping.
module rr_picker
    import process_scheduler_pkg::*;
#(
    parameter int NPROC = NPROC_DEFAULT,
    parameter int PID_W = $clog2(NPROC)
) (
    input  logic [NPROC-1:0] mask,
    input  logic [PID_W-1:0] start,
    output logic             found,
    output logic [PID_W-1:0] pid
);
    logic [PID_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit is the one kept.
    always_comb begin
        found = 1'b0;
        pid   = start;
        idx   = start;
        for (int k = NPROC - 1; k >= 0; k--) begin
            idx = start + PID_W'(k);
            if (mask[idx]) begin
                found = 1'b1;
                pid   = idx;
            end
        end
    end
endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: saves the interrupted PC, picks the next READY entry, loads fetch.
module process_scheduler
    import process_scheduler_pkg::*;
#(
    parameter int              NPROC = NPROC_DEFAULT,
    parameter int              PC_W  = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] OS_PC = '0,
    parameter int              PID_W = $clog2(NPROC)
) (
    input logic                clock,
    input logic                reset,
    process_scheduler_if.slave sched_if
);
    fsm_state_t       fsm_reg, fsm_next;
    logic [PID_W-1:0] cur_pid_reg;
    logic             cur_valid_reg;
    logic [PC_W-1:0]  pc_next_reg;
    logic             sel_found_reg;
    logic [PID_W-1:0] sel_pid_reg;

    logic [NPROC-1:0] ready_mask;
    logic [NPROC-1:0] free_mask;
    logic [PC_W-1:0]  entry_pc [NPROC];

    logic             run_active;
    logic             ev_end, ev_io, ev_qe, ev_any;
    logic             create_fire;
    logic [PID_W-1:0] create_idx;
    logic [PID_W-1:0] pick_start;
    logic             pick_found;
    logic [PID_W-1:0] pick_pid;
    logic             pc_load_next;
    logic             busy_next;

    // One event per cycle, and only while a user process is actually running.
    assign run_active = (fsm_reg == FSM_RUN);
    assign ev_end     = run_active & sched_if.proc_end;
    assign ev_io      = run_active & ~sched_if.proc_end & sched_if.io_request;
    assign ev_qe      = run_active & ~sched_if.proc_end & ~sched_if.io_request
                        & sched_if.quantum_expired;
    assign ev_any     = ev_end | ev_io | ev_qe;

    assign create_fire = sched_if.create_valid & (|free_mask);

    always_comb begin
        create_idx = '0;
        for (int i = NPROC - 1; i >= 0; i--) begin
            if (free_mask[i]) create_idx = PID_W'(i);
        end
    end

    assign pick_start = cur_pid_reg + PID_W'(1);

    rr_picker #(
        .NPROC (NPROC),
        .PID_W (PID_W)
    ) u_rr_picker (
        .mask  (ready_mask),
        .start (pick_start),
        .found (pick_found),
        .pid   (pick_pid)
    );

    // Entry updates never collide: events hit the RUNNING entry, LOAD a READY one,
    // create a FREE one and io_done a BLOCKED one.
    genvar gi;
    for (gi = 0; gi < NPROC; gi++) begin : g_entry
        entry_state_t    state_reg;
        logic [PC_W-1:0] pc_reg;
        logic            is_cur, is_sel, is_create, is_io_done;

        assign is_cur     = (cur_pid_reg == PID_W'(gi));
        assign is_sel     = (fsm_reg == FSM_LOAD) & sel_found_reg & (sel_pid_reg == PID_W'(gi));
        assign is_create  = create_fire & (create_idx == PID_W'(gi));
        assign is_io_done = sched_if.io_done_valid & (sched_if.io_done_pid == PID_W'(gi))
                            & (state_reg == ENTRY_BLOCKED);

        always_ff @(posedge clock) begin
            if (reset) begin
                state_reg <= ENTRY_FREE;
                pc_reg    <= '0;
            end else if (is_cur && ev_end) begin
                state_reg <= ENTRY_FREE;
            end else if (is_cur && ev_io) begin
                state_reg <= ENTRY_BLOCKED;
                pc_reg    <= sched_if.saved_pc;
            end else if (is_cur && ev_qe) begin
                state_reg <= ENTRY_READY;
                pc_reg    <= sched_if.saved_pc;
            end else if (is_sel) begin
                state_reg <= ENTRY_RUNNING;
            end else if (is_create) begin
                state_reg <= ENTRY_READY;
                pc_reg    <= sched_if.create_pc;
            end else if (is_io_done) begin
                state_reg <= ENTRY_READY;
            end
        end

        assign ready_mask[gi] = (state_reg == ENTRY_READY);
        assign free_mask[gi]  = (state_reg == ENTRY_FREE);
        assign entry_pc[gi]   = pc_reg;
    end

    always_comb begin
        fsm_next     = fsm_reg;
        pc_load_next = 1'b0;
        busy_next    = 1'b0;
        unique case (fsm_reg)
            FSM_IDLE:   if (|ready_mask) fsm_next = FSM_SELECT;
            FSM_RUN:    if (ev_any) fsm_next = FSM_SELECT;
            FSM_SELECT: begin
                fsm_next  = FSM_LOAD;
                busy_next = 1'b1;
            end
            FSM_LOAD: begin
                fsm_next     = sel_found_reg ? FSM_RUN : FSM_IDLE;
                pc_load_next = 1'b1;
                busy_next    = 1'b1;
            end
            default:    fsm_next = FSM_IDLE;
        endcase
    end

    // The search result and its PC are captured leaving SELECT so pc_next is
    // already valid in the cycle pc_load is high; cur_pid follows at the end of LOAD.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_reg       <= FSM_IDLE;
            cur_pid_reg   <= '0;
            cur_valid_reg <= 1'b0;
            pc_next_reg   <= OS_PC;
            sel_found_reg <= 1'b0;
            sel_pid_reg   <= '0;
        end else begin
            fsm_reg <= fsm_next;
            if (fsm_reg == FSM_SELECT) begin
                sel_found_reg <= pick_found;
                sel_pid_reg   <= pick_pid;
                pc_next_reg   <= pick_found ? entry_pc[pick_pid] : OS_PC;
            end
            if (fsm_reg == FSM_LOAD) begin
                cur_valid_reg <= sel_found_reg;
                if (sel_found_reg) cur_pid_reg <= sel_pid_reg;
            end
        end
    end

    assign sched_if.create_ready = |free_mask;
    assign sched_if.pc_load      = pc_load_next;
    assign sched_if.pc_next      = pc_next_reg;
    assign sched_if.cur_pid      = cur_pid_reg;
    assign sched_if.cur_valid    = cur_valid_reg;
    assign sched_if.sched_busy   = busy_next;

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: directed scenarios then random traffic, all against a table model.
module tb_process_scheduler;
    localparam int              NPROC = 4;
    localparam int              PC_W  = 32;
    localparam int              PID_W = 2;
    localparam logic [PC_W-1:0] OS_PC = 32'h0;

    localparam int S_FREE = 0, S_READY = 1, S_RUNNING = 2, S_BLOCKED = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    process_scheduler_if #(.PC_W(PC_W), .PID_W(PID_W)) sif ();

    process_scheduler #(
        .NPROC (NPROC),
        .PC_W  (PC_W),
        .OS_PC (OS_PC),
        .PID_W (PID_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sched_if (sif)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: process table plus the pending context switch.
    int              m_st [NPROC];
    logic [PC_W-1:0] m_pc [NPROC];
    int              m_cur;
    bit              m_valid;
    int              m_stage;      // 0 none, 1 searching, 2 loading
    bit              m_found;
    int              m_sel;
    logic [PC_W-1:0] m_pc_next;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int old_st [NPROC];
        int nstage;
        bit any_ready;
        if (reset) begin
            for (int p = 0; p < NPROC; p++) begin
                m_st[p] = S_FREE;
                m_pc[p] = '0;
            end
            m_cur = 0; m_valid = 0; m_stage = 0; m_found = 0; m_sel = 0;
            m_pc_next = OS_PC;
            return;
        end
        old_st    = m_st;
        nstage    = m_stage;
        any_ready = 0;
        for (int p = 0; p < NPROC; p++) if (old_st[p] == S_READY) any_ready = 1;
        if (m_stage == 0) begin
            if (m_valid) begin
                if (sif.proc_end) begin
                    m_st[m_cur] = S_FREE; nstage = 1;
                end else if (sif.io_request) begin
                    m_st[m_cur] = S_BLOCKED; m_pc[m_cur] = sif.saved_pc; nstage = 1;
                end else if (sif.quantum_expired) begin
                    m_st[m_cur] = S_READY; m_pc[m_cur] = sif.saved_pc; nstage = 1;
                end
            end else if (any_ready) begin
                nstage = 1;
            end
        end else if (m_stage == 1) begin
            m_found = 0;
            for (int k = 1; k <= NPROC; k++) begin
                int p;
                p = (m_cur + k) % NPROC;
                if (!m_found && old_st[p] == S_READY) begin
                    m_found = 1; m_sel = p;
                end
            end
            m_pc_next = m_found ? m_pc[m_sel] : OS_PC;
            nstage = 2;
        end else begin
            if (m_found) begin
                m_st[m_sel] = S_RUNNING; m_cur = m_sel; m_valid = 1;
            end else begin
                m_valid = 0;
            end
            nstage = 0;
        end
        if (sif.create_valid) begin
            bit done;
            done = 0;
            for (int p = 0; p < NPROC; p++) begin
                if (!done && old_st[p] == S_FREE) begin
                    m_st[p] = S_READY; m_pc[p] = sif.create_pc; done = 1;
                end
            end
        end
        if (sif.io_done_valid && old_st[int'(sif.io_done_pid)] == S_BLOCKED)
            m_st[int'(sif.io_done_pid)] = S_READY;
        m_stage = nstage;
    endtask

    task automatic compare_outputs();
        bit any_free;
        any_free = 0;
        for (int p = 0; p < NPROC; p++) if (m_st[p] == S_FREE) any_free = 1;
        check_value("pc_load", sif.pc_load, m_stage == 2);
        check_value("pc_next", sif.pc_next, m_pc_next);
        check_value("sched_busy", sif.sched_busy, m_stage != 0);
        check_value("create_ready", sif.create_ready, any_free);
        check_value("cur_valid", sif.cur_valid, m_valid);
        if (m_valid) check_value("cur_pid", sif.cur_pid, m_cur);
        if (sif.pc_load)
            $display("[TB] t=%0t load pc_next=%0h (from pid %0d search)", $time, sif.pc_next, sif.cur_pid);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic clear_inputs();
        sif.quantum_expired = 0; sif.io_request = 0; sif.proc_end = 0; sif.saved_pc = '0;
        sif.create_valid = 0; sif.create_pc = '0; sif.io_done_valid = 0; sif.io_done_pid = '0;
    endtask

    task automatic wait_load(output int n);
        n = 0;
        while (!sif.pc_load && n < 20) begin
            step();
            n++;
        end
        if (!sif.pc_load) check_value("load_timeout", 0, 1);
    endtask

    task automatic create(input logic [PC_W-1:0] pc);
        sif.create_valid = 1; sif.create_pc = pc;
        step();
        sif.create_valid = 0;
    endtask

    // Raise one event for a single edge; sel: 0 proc_end, 1 io_request, 2 quantum_expired
    task automatic event_pulse(input int sel, input logic [PC_W-1:0] pc);
        sif.proc_end = (sel == 0); sif.io_request = (sel == 1); sif.quantum_expired = (sel == 2);
        sif.saved_pc = pc;
        step();
        clear_inputs();
    endtask

    task automatic expect_switch(input string tag, input logic [PC_W-1:0] pc, input int pid);
        int n;
        wait_load(n);
        check_value({tag, "_lat"}, n, 1);
        check_value({tag, "_pc"}, sif.pc_next, pc);
        step();
        check_value({tag, "_pid"}, sif.cur_pid, pid);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        clear_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        check_value("rst_pc_load", sif.pc_load, 0);
        check_value("rst_pc_next", sif.pc_next, OS_PC);
        check_value("rst_cur_pid", sif.cur_pid, 0);
        check_value("rst_cur_valid", sif.cur_valid, 0);
        check_value("rst_busy", sif.sched_busy, 0);
        check_value("rst_create_ready", sif.create_ready, 1);

        // First create from idle: load appears three cycles after the accepting edge
        create(32'd400);
        wait_load(n);
        check_value("lat_create", n + 1, 3);
        check_value("first_pc", sif.pc_next, 32'd400);
        step();
        check_value("first_pid", sif.cur_pid, 0);
        create(32'd500);
        create(32'd600);

        event_pulse(2, 32'd405);
        expect_switch("qe_rr", 32'd500, 1);
        event_pulse(1, 32'd512);
        expect_switch("io_req", 32'd600, 2);
        sif.io_done_valid = 1; sif.io_done_pid = 2'd1;
        step();
        clear_inputs();
        event_pulse(2, 32'd605);
        expect_switch("wrap", 32'd405, 0);
        event_pulse(2, 32'd410);
        expect_switch("io_back", 32'd512, 1);

        event_pulse(0, 32'd0);
        expect_switch("end1", 32'd605, 2);
        event_pulse(0, 32'd0);
        expect_switch("end2", 32'd410, 0);
        event_pulse(0, 32'd0);
        wait_load(n);
        check_value("end_last_pc", sif.pc_next, OS_PC);
        step();
        check_value("end_last_valid", sif.cur_valid, 0);
        check_value("end_last_busy", sif.sched_busy, 0);
        check_value("end_last_ready", sif.create_ready, 1);

        // Single process reloads itself two cycles after the event
        create(32'd700);
        wait_load(n);
        check_value("single_first", sif.pc_next, 32'd700);
        step();
        event_pulse(2, 32'd777);
        step();
        check_value("single_reload", sif.pc_load, 1);
        check_value("single_pc", sif.pc_next, 32'd777);
        step();

        // Full table: create ignored, freed pid reusable one cycle after proc_end
        create(32'h1001); create(32'h1002); create(32'h1003);
        check_value("full_ready", sif.create_ready, 0);
        create(32'h999);
        sif.proc_end = 1;
        step();
        clear_inputs();
        check_value("freed_ready", sif.create_ready, 1);
        create(32'h2000);
        wait_load(n);
        check_value("full_next_pc", sif.pc_next, 32'h1001);
        step();

        // proc_end beats quantum_expired in the same cycle
        sif.proc_end = 1; sif.quantum_expired = 1; sif.saved_pc = 32'hdead;
        step();
        clear_inputs();
        check_value("prio_freed", sif.create_ready, 1);
        expect_switch("prio", 32'h1002, 2);

        // Reset during LOAD aborts the switch
        event_pulse(2, 32'h3333);
        step();
        check_value("abort_in_load", sif.pc_load, 1);
        reset = 1;
        step();
        reset = 0;
        check_value("abort_pc_load", sif.pc_load, 0);
        check_value("abort_pc_next", sif.pc_next, OS_PC);
        check_value("abort_valid", sif.cur_valid, 0);
        check_value("abort_pid", sif.cur_pid, 0);
        check_value("abort_ready", sif.create_ready, 1);

        for (int c = 0; c < 3000; c++) begin
            sif.proc_end        = ($urandom_range(0, 15) == 0);
            sif.io_request      = ($urandom_range(0, 7) == 0);
            sif.quantum_expired = ($urandom_range(0, 3) == 0);
            sif.saved_pc        = $urandom;
            sif.create_valid    = ($urandom_range(0, 3) == 0);
            sif.create_pc       = $urandom;
            sif.io_done_valid   = ($urandom_range(0, 3) == 0);
            sif.io_done_pid     = PID_W'($urandom_range(0, NPROC - 1));
            reset               = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 0;
        clear_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
